munoc_axi4_sram_slave_responder: RTL

//  AXI4 slave responder backed by a register-file SRAM; it is the far end of the sx4* port set driven by the

---
 rtl/munoc_axi4_sram_slave_responder_pkg.sv | 24 ++
 rtl/munoc_axi4_sram_slave_responder_burst_addr_gen.sv | 50 +++++
 rtl/munoc_axi4_sram_slave_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/munoc_axi4_sram_slave_responder_pkg.sv
// rtl/munoc_axi4_sram_slave_responder_pkg.sv - shared AXI widths, encodings and FSM states
// Purpose: common definitions for the SRAM-backed AXI4 slave responder and its burst address generator.
// Ports: none (package).
package munoc_axi4_sram_slave_responder_pkg;

   localparam int BW_AXI_ALEN        = 8;
   localparam int BW_AXI_ASIZE       = 3;
   localparam int BW_AXI_ABURST      = 2;
   localparam int BW_AXI_BRESP       = 2;
   localparam int BW_AXI_RRESP       = 2;
   localparam int DEFAULT_BW_AXI_TID = 4;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

endpackage

// File: rtl/munoc_axi4_sram_slave_responder_burst_addr_gen.sv
// rtl/munoc_axi4_sram_slave_responder_burst_addr_gen.sv - combinational AXI burst next-address and error check
// Purpose: given the current beat address and burst attributes, produce the next beat address and flag
//  transactions the memory cannot serve.
// Ports: addr_i/size_i/len_i/burst_i in; next_addr_o (FIXED/INCR/WRAP stepping), err_o (SLVERR condition).
module munoc_axi4_sram_slave_responder_burst_addr_gen
   import munoc_axi4_sram_slave_responder_pkg::*;
#(
   parameter int BW_ADDR    = 32,
   parameter int BW_DATA    = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic [BW_ADDR-1:0]       addr_i,
   input  logic [BW_AXI_ASIZE-1:0]  size_i,
   input  logic [BW_AXI_ALEN-1:0]   len_i,
   input  logic [BW_AXI_ABURST-1:0] burst_i,
   output logic [BW_ADDR-1:0]       next_addr_o,
   output logic                     err_o
);

   localparam int LANE_LOG2 = $clog2(BW_DATA / 8);
   localparam int MEM_LOG2  = DEPTH_LOG2 + LANE_LOG2;

   logic [BW_ADDR-1:0] step, incr, size_mask, win_mask, wrap_addr;
   logic               is_wrap, range_err, size_err, wrap_err, rsvd_err;

   always_comb begin
      step      = BW_ADDR'(1) << size_i;
      incr      = addr_i + step;
      size_mask = step - BW_ADDR'(1);
      // wrap window is (len+1) beats of (1<<size) bytes, aligned to its own size
      win_mask  = ((BW_ADDR'(len_i) + BW_ADDR'(1)) << size_i) - BW_ADDR'(1);
      wrap_addr = (addr_i & ~win_mask) | (incr & win_mask);

      is_wrap   = (burst_i == BURST_WRAP);
      range_err = (addr_i >> MEM_LOG2) != '0;
      size_err  = int'(size_i) > LANE_LOG2;
      wrap_err  = is_wrap && (!(len_i inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                              ((addr_i & size_mask) != '0));
      rsvd_err  = (burst_i == BURST_RSVD);
      err_o     = range_err | size_err | wrap_err | rsvd_err;

      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         BURST_INCR:  next_addr_o = incr;
         BURST_WRAP:  next_addr_o = wrap_addr;
         default:     next_addr_o = addr_i;
      endcase
   end

endmodule

// File: rtl/munoc_axi4_sram_slave_responder.sv
// rtl/munoc_axi4_sram_slave_responder.sv - AXI4 slave responder backed by a register-file SRAM
// Purpose: accepts one write (AW/W->B) and one read (AR->R) at a time, runs FIXED/INCR/WRAP bursts
//  against an inferred memory with one write and one read port.
// Ports: clk_i, rstnn_i (async active-low); sx4aw*/sx4w*/sx4b* write channels; sx4ar*/sx4r* read channels.
module munoc_axi4_sram_slave_responder
   import munoc_axi4_sram_slave_responder_pkg::*;
#(
   parameter int BW_PLATFORM_ADDR = 32,
   parameter int BW_NODE_DATA     = 32,
   parameter int BW_AXI_SLAVE_TID = DEFAULT_BW_AXI_TID,
   parameter int DEPTH_LOG2       = 10
) (
   input  logic                        clk_i,
   input  logic                        rstnn_i,
   input  logic [BW_AXI_SLAVE_TID-1:0] sx4awid_i,
   input  logic [BW_PLATFORM_ADDR-1:0] sx4awaddr_i,
   input  logic [BW_AXI_ALEN-1:0]      sx4awlen_i,
   input  logic [BW_AXI_ASIZE-1:0]     sx4awsize_i,
   input  logic [BW_AXI_ABURST-1:0]    sx4awburst_i,
   input  logic                        sx4awvalid_i,
   output logic                        sx4awready_o,
   input  logic [BW_NODE_DATA-1:0]     sx4wdata_i,
   input  logic [BW_NODE_DATA/8-1:0]   sx4wstrb_i,
   input  logic                        sx4wlast_i,
   input  logic                        sx4wvalid_i,
   output logic                        sx4wready_o,
   output logic [BW_AXI_SLAVE_TID-1:0] sx4bid_o,
   output logic [BW_AXI_BRESP-1:0]     sx4bresp_o,
   output logic                        sx4bvalid_o,
   input  logic                        sx4bready_i,
   input  logic [BW_AXI_SLAVE_TID-1:0] sx4arid_i,
   input  logic [BW_PLATFORM_ADDR-1:0] sx4araddr_i,
   input  logic [BW_AXI_ALEN-1:0]      sx4arlen_i,
   input  logic [BW_AXI_ASIZE-1:0]     sx4arsize_i,
   input  logic [BW_AXI_ABURST-1:0]    sx4arburst_i,
   input  logic                        sx4arvalid_i,
   output logic                        sx4arready_o,
   output logic [BW_AXI_SLAVE_TID-1:0] sx4rid_o,
   output logic [BW_NODE_DATA-1:0]     sx4rdata_o,
   output logic [BW_AXI_RRESP-1:0]     sx4rresp_o,
   output logic                        sx4rlast_o,
   output logic                        sx4rvalid_o,
   input  logic                        sx4rready_i
);

   localparam int BW_STRB   = BW_NODE_DATA / 8;
   localparam int LANE_LOG2 = $clog2(BW_STRB);
   localparam int MEM_LOG2  = DEPTH_LOG2 + LANE_LOG2;
   localparam int DEPTH     = 1 << DEPTH_LOG2;

   logic [BW_NODE_DATA-1:0] mem_q [DEPTH];

   // ---------------- write channel state ----------------
   wstate_t                     wstate_q;
   logic                        awready_q, wready_q, bvalid_q;
   logic [BW_AXI_SLAVE_TID-1:0] bid_q;
   logic [BW_AXI_BRESP-1:0]     bresp_q;
   logic [BW_PLATFORM_ADDR-1:0] waddr_q;
   logic [BW_AXI_ALEN-1:0]      wlen_q, wcnt_q;
   logic [BW_AXI_ASIZE-1:0]     wsize_q;
   logic [BW_AXI_ABURST-1:0]    wburst_q;
   logic                        werr_q, wlast_err_q;

   // ---------------- read channel state ----------------
   rstate_t                     rstate_q;
   logic                        arready_q, rvalid_q, rlast_q;
   logic [BW_AXI_SLAVE_TID-1:0] rid_q;
   logic [BW_NODE_DATA-1:0]     rdata_q;
   logic [BW_AXI_RRESP-1:0]     rresp_q;
   logic [BW_PLATFORM_ADDR-1:0] raddr_q;
   logic [BW_AXI_ALEN-1:0]      rlen_q, rcnt_q;
   logic [BW_AXI_ASIZE-1:0]     rsize_q;
   logic [BW_AXI_ABURST-1:0]    rburst_q;
   logic                        rerr_q;

   logic aw_hs, w_hs, ar_hs, mem_we;

   assign aw_hs  = sx4awvalid_i & awready_q;
   assign w_hs   = sx4wvalid_i & wready_q;
   assign ar_hs  = sx4arvalid_i & arready_q;
   assign mem_we = w_hs & ~werr_q;

   // In IDLE the generator looks at the incoming request (error check and first step);
   // during the burst it steps the latched beat address.
   logic [BW_PLATFORM_ADDR-1:0] wg_addr, wg_next_d, rg_addr, rg_next_d;
   logic                        wg_err, rg_err;
   logic [DEPTH_LOG2-1:0]       widx, ridx;

   assign wg_addr = (wstate_q == W_IDLE) ? sx4awaddr_i : waddr_q;
   assign rg_addr = (rstate_q == R_IDLE) ? sx4araddr_i : raddr_q;
   assign widx    = waddr_q[MEM_LOG2-1:LANE_LOG2];
   assign ridx    = rg_addr[MEM_LOG2-1:LANE_LOG2];

   munoc_axi4_sram_slave_responder_burst_addr_gen #(
      .BW_ADDR(BW_PLATFORM_ADDR), .BW_DATA(BW_NODE_DATA), .DEPTH_LOG2(DEPTH_LOG2)
   ) u_wgen (
      .addr_i     (wg_addr),
      .size_i     ((wstate_q == W_IDLE) ? sx4awsize_i  : wsize_q),
      .len_i      ((wstate_q == W_IDLE) ? sx4awlen_i   : wlen_q),
      .burst_i    ((wstate_q == W_IDLE) ? sx4awburst_i : wburst_q),
      .next_addr_o(wg_next_d),
      .err_o      (wg_err)
   );

   munoc_axi4_sram_slave_responder_burst_addr_gen #(
      .BW_ADDR(BW_PLATFORM_ADDR), .BW_DATA(BW_NODE_DATA), .DEPTH_LOG2(DEPTH_LOG2)
   ) u_rgen (
      .addr_i     (rg_addr),
      .size_i     ((rstate_q == R_IDLE) ? sx4arsize_i  : rsize_q),
      .len_i      ((rstate_q == R_IDLE) ? sx4arlen_i   : rlen_q),
      .burst_i    ((rstate_q == R_IDLE) ? sx4arburst_i : rburst_q),
      .next_addr_o(rg_next_d),
      .err_o      (rg_err)
   );

   // Memory: byte-lane write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < BW_STRB; b++) begin
            if (sx4wstrb_i[b]) mem_q[widx][8*b +: 8] <= sx4wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstnn_i) begin
      if (!rstnn_i) begin
         wstate_q    <= W_IDLE;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bid_q       <= '0;
         bresp_q     <= RESP_OKAY;
         waddr_q     <= '0;
         wlen_q      <= '0;
         wcnt_q      <= '0;
         wsize_q     <= '0;
         wburst_q    <= '0;
         werr_q      <= 1'b0;
         wlast_err_q <= 1'b0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (aw_hs) begin
                  awready_q   <= 1'b0;
                  wready_q    <= 1'b1;
                  bid_q       <= sx4awid_i;
                  waddr_q     <= sx4awaddr_i;
                  wlen_q      <= sx4awlen_i;
                  wsize_q     <= sx4awsize_i;
                  wburst_q    <= sx4awburst_i;
                  wcnt_q      <= '0;
                  werr_q      <= wg_err;
                  wlast_err_q <= 1'b0;
                  wstate_q    <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  waddr_q <= wg_next_d;
                  if (wcnt_q == wlen_q) begin
                     // final beat: wlast must be set here and nowhere earlier
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= (werr_q | wlast_err_q | ~sx4wlast_i) ? RESP_SLVERR : RESP_OKAY;
                     wstate_q <= W_RESP;
                  end else begin
                     wcnt_q <= wcnt_q + 1'b1;
                     if (sx4wlast_i) wlast_err_q <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (sx4bready_i) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wstate_q  <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   // Read data is registered from the memory array; a same-cycle write lands after this read (read-first).
   always_ff @(posedge clk_i or negedge rstnn_i) begin
      if (!rstnn_i) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rerr_q    <= 1'b0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rid_q     <= sx4arid_i;
                  rlen_q    <= sx4arlen_i;
                  rsize_q   <= sx4arsize_i;
                  rburst_q  <= sx4arburst_i;
                  rerr_q    <= rg_err;
                  rresp_q   <= rg_err ? RESP_SLVERR : RESP_OKAY;
                  rdata_q   <= rg_err ? '0 : mem_q[ridx];
                  rlast_q   <= (sx4arlen_i == '0);
                  rcnt_q    <= '0;
                  raddr_q   <= rg_next_d;
                  rstate_q  <= R_DATA;
               end
            end
            R_DATA: begin
               if (sx4rready_i) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     rdata_q   <= '0;
                     arready_q <= 1'b1;
                     rstate_q  <= R_IDLE;
                  end else begin
                     rdata_q <= rerr_q ? '0 : mem_q[ridx];
                     raddr_q <= rg_next_d;
                     rcnt_q  <= rcnt_q + 1'b1;
                     rlast_q <= ((rcnt_q + 1'b1) == rlen_q);
                  end
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   assign sx4awready_o = awready_q;
   assign sx4wready_o  = wready_q;
   assign sx4bvalid_o  = bvalid_q;
   assign sx4bid_o     = bid_q;
   assign sx4bresp_o   = bresp_q;
   assign sx4arready_o = arready_q;
   assign sx4rvalid_o  = rvalid_q;
   assign sx4rid_o     = rid_q;
   assign sx4rdata_o   = rdata_q;
   assign sx4rresp_o   = rresp_q;
   assign sx4rlast_o   = rlast_q;

endmodule
